single_sum_v: RTL

SINGLE_SUM_V -- requirements
Module: single_sum_v

---
 rtl/single_pkg.sv | 43 ++++
 rtl/single_add.sv | 127 ++++++++++++
 rtl/single_sum_v.sv | 106 ++++++++++
 3 files changed

// File: rtl/single_pkg.sv
// Shared definitions for the single-precision vector sum block.
// Holds the controller state encoding, binary32 constants and small
// field-extract / classification helpers used by the adder and the top.
package single_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam int          EXP_BIAS = 127;
  // All-ones exponent (Inf/NaN encoding), derived from the bias.
  localparam logic [7:0]  EXP_ALL1 = 8'(2 * EXP_BIAS + 1);

  function automatic logic f_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] f_man(input logic [31:0] f);
    return f[22:0];
  endfunction

  function automatic logic f_is_nan(input logic [31:0] f);
    return (f[30:23] == EXP_ALL1) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic f_is_inf(input logic [31:0] f);
    return (f[30:23] == EXP_ALL1) && (f[22:0] == 23'd0);
  endfunction

  // Zero exponent covers true zeros and denormals (flushed to zero).
  function automatic logic f_is_zero(input logic [31:0] f);
    return (f[30:23] == 8'd0);
  endfunction

endpackage

// File: rtl/single_add.sv
// Combinational IEEE-754 binary32 adder, round-to-nearest-even,
// denormals flushed to zero (sign kept), canonical NaN output.
// Ports:
//   a, b : binary32 operands
//   c    : binary32 sum
module single_add
  import single_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  logic        big_s_s;
  logic [7:0]  big_e_s;
  logic [22:0] big_m_s;
  logic        sml_s_s;
  logic [7:0]  sml_e_s;
  logic [22:0] sml_m_s;
  logic [7:0]  exp_diff_s;
  logic [49:0] sml_wide_s;
  logic [26:0] big_al_s;
  logic [26:0] sml_al_s;
  logic [27:0] raw_s;
  logic [26:0] norm_s;
  logic [4:0]  lz_s;
  logic signed [9:0] exp_s;
  logic        rnd_up_s;
  logic [24:0] rnd_s;
  logic [22:0] man_s;
  logic [31:0] gen_s;

  // Leading-zero count of a 27-bit value; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) begin
        n = 5'(26 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Finite-operand datapath plus special-case selection.
  always_comb begin
    lz_s = 5'd0;
    // Order operands by magnitude so the subtraction is never negative.
    if (a[30:0] >= b[30:0]) begin
      big_s_s = f_sign(a); big_e_s = f_exp(a); big_m_s = f_man(a);
      sml_s_s = f_sign(b); sml_e_s = f_exp(b); sml_m_s = f_man(b);
    end else begin
      big_s_s = f_sign(b); big_e_s = f_exp(b); big_m_s = f_man(b);
      sml_s_s = f_sign(a); sml_e_s = f_exp(a); sml_m_s = f_man(a);
    end

    // Align the smaller operand: 24-bit significand plus guard/round/sticky.
    exp_diff_s = big_e_s - sml_e_s;
    sml_wide_s = {1'b1, sml_m_s, 26'd0} >> exp_diff_s;
    big_al_s   = {1'b1, big_m_s, 3'b000};
    if (exp_diff_s > 8'd26) begin
      sml_al_s = 27'd1;
    end else begin
      sml_al_s = {sml_wide_s[49:24], sml_wide_s[23] | (|sml_wide_s[22:0])};
    end

    if (big_s_s ^ sml_s_s) begin
      raw_s = {1'b0, big_al_s} - {1'b0, sml_al_s};
    end else begin
      raw_s = {1'b0, big_al_s} + {1'b0, sml_al_s};
    end

    // Normalize: one right shift on carry-out, else left by leading zeros.
    exp_s = $signed({2'b00, big_e_s});
    if (raw_s[27]) begin
      norm_s = {raw_s[27:2], raw_s[1] | raw_s[0]};
      exp_s  = exp_s + 10'sd1;
    end else begin
      lz_s   = lzc27(raw_s[26:0]);
      norm_s = raw_s[26:0] << lz_s;
      exp_s  = exp_s - $signed({5'd0, lz_s});
    end

    // Round to nearest, ties to even (lsb is norm_s[3]).
    rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s    = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
    if (rnd_s[24]) begin
      exp_s = exp_s + 10'sd1;
      man_s = rnd_s[23:1];
    end else begin
      man_s = rnd_s[22:0];
    end

    if (raw_s == 28'd0) begin
      gen_s = POS_ZERO;
    end else if (exp_s <= 10'sd0) begin
      gen_s = {big_s_s, 31'd0};
    end else if (exp_s >= $signed({2'b00, EXP_ALL1})) begin
      gen_s = {big_s_s, EXP_ALL1, 23'd0};
    end else begin
      gen_s = {big_s_s, exp_s[7:0], man_s};
    end

    // Special operands override the datapath result.
    if (f_is_nan(a) || f_is_nan(b)) begin
      c = QNAN;
    end else if (f_is_inf(a) && f_is_inf(b)) begin
      c = (f_sign(a) != f_sign(b)) ? QNAN : {f_sign(a), EXP_ALL1, 23'd0};
    end else if (f_is_inf(a)) begin
      c = {f_sign(a), EXP_ALL1, 23'd0};
    end else if (f_is_inf(b)) begin
      c = {f_sign(b), EXP_ALL1, 23'd0};
    end else if (f_is_zero(a) && f_is_zero(b)) begin
      // -0 + -0 stays -0; every other zero pairing gives +0.
      c = {f_sign(a) & f_sign(b), 31'd0};
    end else if (f_is_zero(a)) begin
      c = b;
    end else if (f_is_zero(b)) begin
      c = a;
    end else begin
      c = gen_s;
    end
  end

endmodule

// File: rtl/single_sum_v.sv
// Sequential left-to-right binary32 sum of a WIDTH-element vector.
// One shared adder accumulates one element per cycle.
// Ports:
//   clk      : clock, rising edge
//   rstn     : synchronous active-high reset
//   start    : one-cycle request, vector_a sampled on the same edge
//   vector_a : WIDTH binary32 operands
//   busy     : high while accumulating or presenting the result
//   done     : one-cycle pulse, sum valid
//   sum      : binary32 result, held until the next result
module single_sum_v
  import single_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] vector_a [WIDTH],
  output logic        busy,
  output logic        done,
  output logic [31:0] sum
);

  localparam int IDX_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      vec_r [WIDTH];
  logic [31:0]      acc_r;
  logic [31:0]      sum_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r;
  logic             done_r;
  logic [31:0]      add_b_s;
  logic [31:0]      add_res_s;

  // Select the current element for the shared adder.
  always_comb begin
    add_b_s = vec_r[0];
    for (int i = 0; i < WIDTH; i++) begin
      add_b_s = (idx_r == IDX_W'(i)) ? vec_r[i] : add_b_s;
    end
  end

  single_add u_add (
    .a (acc_r),
    .b (add_b_s),
    .c (add_res_s)
  );

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? ACCUM : IDLE;
      ACCUM:   state_nxt_s = (idx_r == LAST_IDX) ? DONE : ACCUM;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r <= IDLE;
      acc_r   <= POS_ZERO;
      sum_r   <= POS_ZERO;
      idx_r   <= {IDX_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        vec_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      // done follows the DONE state by one register stage.
      done_r  <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            vec_r <= vector_a;
            acc_r <= POS_ZERO;
            idx_r <= {IDX_W{1'b0}};
          end
        end
        ACCUM: begin
          acc_r <= add_res_s;
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            sum_r <= add_res_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;

endmodule
